// File: rtl/serial_subtractor_n_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master = operand source / result sink, slave = the subtractor itself.
interface serial_subtractor_n_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, busy
  );
endinterface

// File: rtl/serial_subtractor_n.sv
// Bit-serial N-bit subtractor: A - B - Bin, LSB first, one full-subtractor
// cell and a borrow flop; N RUN cycles per operation.
module serial_subtractor_n #(
  parameter int N = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_subtractor_n_if.slave bus
);
  localparam int              CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [N-1:0]  res_q, res_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sa_msb_q, sa_msb_d;
  logic          sb_msb_q, sb_msb_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          ovf_q, ovf_d;

  logic          x, y, r, d, brw;
  logic [N-1:0]  res_shift;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    x         = sa_q[0];
    y         = sb_q[0];
    r         = br_q;
    d         = x ^ y ^ r;
    brw       = (~x & y) | (~x & r) | (y & r);
    res_shift = res_q >> 1;
    res_shift[N-1] = d;
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    sa_msb_d = sa_msb_q;
    sb_msb_d = sb_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sa_d     = bus.a;
          sb_d     = bus.b;
          br_d     = bus.bin;
          cnt_d    = '0;
          sa_msb_d = bus.a[N-1];
          sb_msb_d = bus.b[N-1];
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = res_shift;
        br_d  = brw;
        if (cnt_q == CNT_LAST) begin
          // Results are captured separately so they survive the next operation
          diff_d  = res_shift;
          bout_d  = brw;
          ovf_d   = (sa_msb_q != sb_msb_q) && (d != sa_msb_q);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      sa_msb_q <= 1'b0;
      sb_msb_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      sa_msb_q <= sa_msb_d;
      sb_msb_q <= sb_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_subtractor_n.sv
// Bench for serial_subtractor_n: directed vectors on N=8, then random traffic
// with stalls on N=8 and N=1, checked every cycle against an arithmetic model.
module tb_serial_subtractor_n;
  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  int   acc8;
  logic rnd_on;

  exp_t sb     [2][$];
  exp_t last_e [2];

  serial_subtractor_n_if #(.N(8)) if8 ();
  serial_subtractor_n_if #(.N(1)) if1 ();

  serial_subtractor_n #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_subtractor_n #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input int k, input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h want %0h", nm, (k == 0) ? 8 : 1, cyc, act, exp);
    end
  endtask

  // Reference: plain integer subtraction; ovf follows the sign-bit rule on a, b, diff
  function automatic exp_t model(input int n, input logic [7:0] a, input logic [7:0] b, input logic bi);
    exp_t e;
    int   m;
    int   t;
    m      = (1 << n) - 1;
    t      = int'(a & 8'(m)) - int'(b & 8'(m)) - int'(bi);
    e.diff = 8'(t & m);
    e.bout = (t < 0);
    e.ovf  = (a[n-1] != b[n-1]) && (e.diff[n-1] != a[n-1]);
    e.acc  = 0;
    return e;
  endfunction

  task automatic step(input int k, input int n, input logic ov, input logic ir, input logic bsy,
                      input logic [7:0] df, input logic bo, input logic of_, input logic iv,
                      input logic [7:0] a, input logic [7:0] b, input logic bi, input logic ordy);
    exp_t cur;
    exp_t nw;
    logic e_ov;
    logic e_ir;
    logic e_bsy;
    e_ir  = (sb[k].size() == 0);
    e_ov  = !e_ir && (cyc >= sb[k][0].acc + n + 1);
    e_bsy = !e_ir && !e_ov;
    cur   = e_ov ? sb[k][0] : last_e[k];
    chk(k, "out_valid", 8'(ov), 8'(e_ov));
    chk(k, "in_ready", 8'(ir), 8'(e_ir));
    chk(k, "busy", 8'(bsy), 8'(e_bsy));
    chk(k, "diff", df, cur.diff);
    chk(k, "bout", 8'(bo), 8'(cur.bout));
    chk(k, "ovf", 8'(of_), 8'(cur.ovf));
    if (e_ov && ordy) begin
      last_e[k] = sb[k][0];
      void'(sb[k].pop_front());
    end
    if (iv && e_ir) begin
      nw     = model(n, a, b, bi);
      nw.acc = cyc;
      sb[k].push_back(nw);
    end
  endtask

  task automatic clear_model(input int k);
    sb[k].delete();
    last_e[k].diff = '0;
    last_e[k].bout = 1'b0;
    last_e[k].ovf  = 1'b0;
    last_e[k].acc  = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) clear_model(0);
    else step(0, 8, if8.out_valid, if8.in_ready, if8.busy, if8.diff, if8.bout, if8.ovf,
              if8.in_valid, if8.a, if8.b, if8.bin, if8.out_ready);
  end

  always @(negedge clk) begin
    if (!rst_n) clear_model(1);
    else step(1, 1, if1.out_valid, if1.in_ready, if1.busy, {7'b0, if1.diff}, if1.bout, if1.ovf,
              if1.in_valid, {7'b0, if1.a}, {7'b0, if1.b}, if1.bin, if1.out_ready);
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      if8.out_ready = ($urandom_range(0, 3) != 0);
      if1.out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int n;
    if8.a = a; if8.b = b; if8.bin = bi; if8.in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!if8.in_ready && n < 300);
    if (!if8.in_ready) chk(0, "send_timeout", 8'(if8.in_ready), 8'd1);
    acc8 = cyc;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
  endtask

  task automatic send1(input logic a, input logic b, input logic bi);
    int n;
    if1.a = a; if1.b = b; if1.bin = bi; if1.in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!if1.in_ready && n < 300);
    if (!if1.in_ready) chk(1, "send_timeout", 8'(if1.in_ready), 8'd1);
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
  endtask

  task automatic wait_out8(input string nm, input logic [7:0] d, input logic bo, input logic of_);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!if8.out_valid && n < 100);
    chk(0, {nm, "_valid"}, 8'(if8.out_valid), 8'd1);
    chk(0, {nm, "_latency"}, 8'(cyc - acc8), 8'd9);
    chk(0, {nm, "_diff"}, if8.diff, d);
    chk(0, {nm, "_bout"}, 8'(if8.bout), 8'(bo));
    chk(0, {nm, "_ovf"}, 8'(if8.ovf), 8'(of_));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; cyc = 0; acc8 = 0; rnd_on = 1'b0;
    rst_n = 1'b0;
    if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.bin = 0; if8.out_ready = 1;
    if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.bin = 0; if1.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(0, "rst_out_valid", 8'(if8.out_valid), 8'd0);
    chk(0, "rst_in_ready", 8'(if8.in_ready), 8'd1);
    chk(0, "rst_diff", if8.diff, 8'h00);
    chk(0, "rst_busy", 8'(if8.busy), 8'd0);
    chk(1, "rst_in_ready", 8'(if1.in_ready), 8'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // basic, borrow, bin-only, signed overflow cases
    send8(8'h05, 8'h03, 1'b0); wait_out8("t1", 8'h02, 1'b0, 1'b0);
    send8(8'h03, 8'h05, 1'b0); wait_out8("t2a", 8'hFE, 1'b1, 1'b0);
    send8(8'h00, 8'h00, 1'b1); wait_out8("t2b", 8'hFF, 1'b1, 1'b0);
    send8(8'h80, 8'h01, 1'b0); wait_out8("t3a", 8'h7F, 1'b0, 1'b1);
    send8(8'h7F, 8'hFF, 1'b0); wait_out8("t3b", 8'h80, 1'b1, 1'b1);
    send8(8'h80, 8'h7F, 1'b1); wait_out8("t3c", 8'h00, 1'b0, 1'b1);

    // backpressure with a pending operand held during RUN/DONE
    if8.out_ready = 1'b0;
    send8(8'h20, 8'h08, 1'b0);
    if8.a = 8'h44; if8.b = 8'h11; if8.bin = 1'b0; if8.in_valid = 1'b1;
    wait_out8("t4a", 8'h18, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(0, "t4_stall_in_ready", 8'(if8.in_ready), 8'd0);
      chk(0, "t4_stall_diff", if8.diff, 8'h18);
    end
    @(posedge clk); #1;
    if8.out_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!if8.in_ready && n < 20);
    chk(0, "t4_reaccept", 8'(if8.in_ready), 8'd1);
    acc8 = cyc;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    wait_out8("t4b", 8'h33, 1'b0, 1'b0);

    // reset in the middle of RUN
    send8(8'hAA, 8'h55, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk(0, "t5_out_valid", 8'(if8.out_valid), 8'd0);
    chk(0, "t5_in_ready", 8'(if8.in_ready), 8'd1);
    chk(0, "t5_diff", if8.diff, 8'h00);
    chk(0, "t5_busy", 8'(if8.busy), 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send8(8'h10, 8'h01, 1'b0); wait_out8("t5b", 8'h0F, 1'b0, 1'b0);

    // random traffic with output stalls, both widths
    rnd_on = 1'b1;
    fork
      for (int i = 0; i < 1000; i++)
        send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      for (int j = 0; j < 1000; j++)
        send1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    join
    rnd_on = 1'b0;
    @(posedge clk); #2;
    if8.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 200) begin
      @(posedge clk); n++;
    end
    chk(0, "drain", 8'(sb[0].size()), 8'd0);
    chk(1, "drain", 8'(sb[1].size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
